// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants: base opcodes, immediate formats and decode FSM states.
package riscv_pkg;

    localparam logic [6:0] LOAD     = 7'h03;
    localparam logic [6:0] MISC_MEM = 7'h0F;
    localparam logic [6:0] OP_IMM   = 7'h13;
    localparam logic [6:0] AUIPC    = 7'h17;
    localparam logic [6:0] STORE    = 7'h23;
    localparam logic [6:0] OP       = 7'h33;
    localparam logic [6:0] LUI      = 7'h37;
    localparam logic [6:0] BRANCH   = 7'h63;
    localparam logic [6:0] JALR     = 7'h67;
    localparam logic [6:0] JAL      = 7'h6F;
    localparam logic [6:0] SYSTEM   = 7'h73;

    typedef enum logic [2:0] {
        IMM_R,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_type_e;

    typedef enum logic {
        RUN,
        BUBBLE
    } id_state_e;

endpackage

// File: rtl/regfile.sv
// Integer register file: two combinational read ports, one write port, x0 hardwired to zero.
// Defining ID_WB_BYPASS_EN forwards a same-cycle writeback to the read ports.
module regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      raddr1,
    input  logic [4:0]      raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] regs [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we && waddr != 5'd0) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
        rdata2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];
`ifdef ID_WB_BYPASS_EN
        if (we && raddr1 != 5'd0 && waddr == raddr1) begin
            rdata1 = wdata;
        end
        if (we && raddr2 != 5'd0 && waddr == raddr2) begin
            rdata2 = wdata;
        end
`endif
    end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: field extraction, immediate generation, load-use interlock and output register.
// Writeback-to-read forwarding in the register file is enabled by defining ID_WB_BYPASS_EN.
module id_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     i_pc,
    input  logic [31:0]     i_instr,
    input  logic            i_valid,
    output logic            o_stall,
    input  logic            i_flush,
    input  logic            i_ex_ready,
    input  logic            i_wb_we,
    input  logic [4:0]      i_wb_rd,
    input  logic [XLEN-1:0] i_wb_data,
    output logic            o_valid,
    output logic [31:0]     o_pc,
    output logic [31:0]     o_imm,
    output logic [XLEN-1:0] o_rs1_data,
    output logic [XLEN-1:0] o_rs2_data,
    output logic [6:0]      o_opcode,
    output logic [2:0]      o_funct3,
    output logic            o_funct7_5,
    output logic [4:0]      o_rs1,
    output logic [4:0]      o_rs2,
    output logic [4:0]      o_rd,
    output logic            o_illegal
);

    logic [6:0]      opcode;
    logic [4:0]      rs1, rs2, rd;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic [31:0]     imm;
    imm_type_e       imm_type;
    logic            rs1_used, rs2_used, legal, hazard, load_en, bubble;
    id_state_e       state, next_state;

    assign opcode = i_instr[6:0];
    assign rs1    = i_instr[19:15];
    assign rs2    = i_instr[24:20];
    assign rd     = i_instr[11:7];

    regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (i_wb_we),
        .waddr  (i_wb_rd),
        .wdata  (i_wb_data),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data)
    );

    always_comb begin
        imm_type = IMM_R;
        case (opcode)
            OP_IMM, LOAD, JALR: imm_type = IMM_I;
            STORE:              imm_type = IMM_S;
            BRANCH:             imm_type = IMM_B;
            LUI, AUIPC:         imm_type = IMM_U;
            JAL:                imm_type = IMM_J;
            default:            imm_type = IMM_R;
        endcase
    end

    always_comb begin
        imm = '0;
        case (imm_type)
            IMM_I: imm = {{20{i_instr[31]}}, i_instr[31:20]};
            IMM_S: imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            IMM_B: imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
            IMM_U: imm = {i_instr[31:12], 12'b0};
            IMM_J: imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    assign rs1_used = !(opcode inside {LUI, AUIPC, JAL});
    assign rs2_used = opcode inside {OP, STORE, BRANCH};
    assign legal    = opcode inside {LOAD, STORE, OP, OP_IMM, BRANCH, JAL, JALR,
                                     LUI, AUIPC, SYSTEM, MISC_MEM};

    // A load still sitting in the output register cannot forward its data yet.
    assign hazard = (state == RUN) && o_valid && (o_opcode == LOAD) && (o_rd != 5'd0) &&
                    ((rs1_used && rs1 == o_rd) || (rs2_used && rs2 == o_rd));

    assign load_en = !o_valid || i_ex_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        o_stall    = 1'b0;
        bubble     = 1'b0;
        if (i_flush) begin
            next_state = RUN;
        end else if (hazard) begin
            o_stall = 1'b1;
            if (i_ex_ready) begin
                bubble     = 1'b1;
                next_state = BUBBLE;
            end
        end else begin
            o_stall = o_valid && !i_ex_ready;
            if (state == BUBBLE) begin
                next_state = RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid    <= 1'b0;
            o_pc       <= '0;
            o_imm      <= '0;
            o_rs1_data <= '0;
            o_rs2_data <= '0;
            o_opcode   <= '0;
            o_funct3   <= '0;
            o_funct7_5 <= 1'b0;
            o_rs1      <= '0;
            o_rs2      <= '0;
            o_rd       <= '0;
            o_illegal  <= 1'b0;
        end else if (i_flush || bubble) begin
            o_valid <= 1'b0;
        end else if (load_en) begin
            o_valid    <= i_valid;
            o_pc       <= i_pc;
            o_imm      <= imm;
            o_rs1_data <= rs1_data;
            o_rs2_data <= rs2_data;
            o_opcode   <= opcode;
            o_funct3   <= i_instr[14:12];
            o_funct7_5 <= i_instr[30];
            o_rs1      <= rs1;
            o_rs2      <= rs2;
            o_rd       <= rd;
            o_illegal  <= !legal;
        end
    end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter XLEN, 32: datapath width.
REQ-002 Parameter NREG, 32: register count; x0 reads as zero.
REQ-003 clk  input  1  rising-edge clock; the block has one clock.
REQ-004 rst  input  1  reset: asynchronous, active-high.
REQ-005 i_pc, i_instr  input  32 each  PC and instruction from fetch.
REQ-006 i_valid  input  1  fetch presents a valid instruction.
REQ-007 o_stall  output  1  fetch holds PC and instruction.
REQ-008 i_flush  input  1  taken branch/jump; kills the instruction in decode.
REQ-009 i_ex_ready  input  1  execute accepts the decode output register.
REQ-010 i_wb_we, i_wb_rd[4:0], i_wb_data[31:0]  input  writeback port.
REQ-011 o_valid  output  1  decode output register holds a live instruction.
REQ-012 o_pc, o_imm, o_rs1_data, o_rs2_data  output  32 each  registered operands.
REQ-013 o_opcode[6:0], o_funct3[2:0], o_funct7_5, o_rs1[4:0], o_rs2[4:0], o_rd[4:0]  output  registered fields.
REQ-014 o_illegal  output  1  registered: opcode not in RV32I base set.

Function
REQ-015 The output register SHALL load when (!o_valid || i_ex_ready), with latency 1 cycle from an accepted fetch.
REQ-016 With i_ex_ready=0 and o_valid=1, all outputs SHALL hold and o_stall SHALL be 1.
REQ-017 The immediate SHALL be sign-extended per type: I (OP-IMM, LOAD, JALR), S, B, U, J; the R-type immediate SHALL be 0.
REQ-018 Register reads SHALL be combinational from i_instr[19:15]/[24:20], sampled into o_rs1_data/o_rs2_data on load.
REQ-019 A read of x0 SHALL return 0; writes to x0 SHALL be ignored.
REQ-020 FSM RUN/BUBBLE: in RUN, load-use hazard = o_valid && o_opcode==LOAD && o_rd!=0 && ((rs1 used && rs1==o_rd) || (rs2 used && rs2==o_rd)).
REQ-021 rs1 is used by all opcodes except LUI/AUIPC/JAL; rs2 is used by R, S and B types.
REQ-022 On a hazard with i_ex_ready=1: the next o_valid=0 (bubble), o_stall=1 for that cycle, state to BUBBLE; BUBBLE returns to RUN after 1 cycle and loads normally.
REQ-023 i_flush SHALL take priority: next o_valid=0, o_stall=0, state to RUN, regardless of hazard or i_ex_ready.
REQ-024 i_valid=0 on load SHALL yield o_valid=0.

Reset
REQ-025 While rst is high: o_valid=0, o_stall=0, every registered output = 0, FSM = RUN, all registers = 0.
REQ-026 Reset asserted mid-stall or mid-bubble SHALL discard the instruction; the first cycle after reset is RUN.

Configuration
REQ-027 ID_WB_BYPASS_EN defined: a write to rs1/rs2 (nonzero) in the same cycle as the read SHALL return i_wb_data.
REQ-028 ID_WB_BYPASS_EN undefined: a same-cycle read SHALL return the old value; the new value is visible the next cycle.

Structure
REQ-029 Package riscv_pkg SHALL hold the opcode constants (LOAD, STORE, OP, OP_IMM, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM, MISC_MEM) and the immediate-type enum.
REQ-030 The register file SHALL be sub-module regfile (2 read ports, 1 write port, bypass under the macro).
REQ-031 Immediate generation and the hazard check SHALL stay in id_stage.

Verification
REQ-032 Reset sequence; i_instr=0x00106293, i_valid=1 -> next cycle o_valid=1, o_rd=5, o_funct3=6, o_imm=1, o_rs1_data=0.
REQ-033 i_instr=0xFE000EE3 (beq x0,x0,-4) -> o_imm=0xFFFFFFFC, o_opcode=0x63.
REQ-034 0x0002A303 (lw x6) then 0x006303B3 (add x7,x6,x6) -> one cycle o_valid=0 and o_stall=1, then add issued once.
REQ-035 i_ex_ready=0 for 3 cycles -> outputs stable and o_stall=1; i_flush during a hazard -> o_valid=0 next cycle, no bubble.
REQ-036 Writeback x5=0xDEADBEEF with same-cycle read of x5 -> 0xDEADBEEF with macro, old value without; write x0 -> read 0.
